sram_arbiter: RTL and testbench

Arbitrates the single base-SRAM port between instruction fetch (Icache refill) and the data memory stage. It sequences each SRAM access through a fixed multi-cycle read/write waveform and returns read data with a one-cycle acknowledge. It drives `inst_stop` to the Icache while the data side owns, or is waiting for, the SRAM. It sits between the Icache/MEM stage and the top-level SRAM pins.

---
 rtl/sram_arbiter_pkg.sv | 27 ++
 rtl/sram_arbiter_phy_seq.sv | 80 ++++++++
 rtl/sram_arbiter.sv | 155 +++++++++++++++
 tb/tb_sram_arbiter.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/sram_arbiter_pkg.sv
// Shared types and defaults for the base-SRAM arbiter and its waveform sequencer.
package sram_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_DONE   = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_e;

    localparam int unsigned ACCESS_CYCLES_DEF = 3;
    localparam int unsigned CNT_W             = 4;
    localparam int unsigned DATA_W            = 32;
    localparam int unsigned BE_W              = 4;

    // Per-access command handed from the arbiter to the sequencer at grant.
    typedef struct packed {
        logic              we;
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] wdata;
    } sram_cmd_t;

endpackage

// File: rtl/sram_arbiter_phy_seq.sv
// Drives one fixed-length SRAM read/write waveform per start pulse and captures read data.
module sram_phy_seq
    import sram_arbiter_pkg::*;
#(
    parameter int unsigned SRAM_AW       = 20,
    parameter int unsigned ACCESS_CYCLES = ACCESS_CYCLES_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  sram_cmd_t          cmd,
    input  logic [SRAM_AW-1:0] addr,
    input  logic [DATA_W-1:0]  sram_rdata,
    output logic               last_c,
    output logic [DATA_W-1:0]  rdata,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [DATA_W-1:0]  sram_wdata,
    output logic               sram_wdata_oe,
    output logic               sram_ce_n,
    output logic               sram_oe_n,
    output logic               sram_we_n,
    output logic [BE_W-1:0]    sram_be_n
);

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(ACCESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] WE_LOW_END = CNT_W'(ACCESS_CYCLES - 2);

    logic             active_q;
    logic             we_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_inc;

    assign last_c  = active_q && (cnt_q == CNT_LAST);
    assign cnt_inc = cnt_q + CNT_W'(1);

    // Strobes are registered so they line up exactly with the ACCESS cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            active_q      <= 1'b0;
            we_q          <= 1'b0;
            cnt_q         <= '0;
            rdata         <= '0;
            sram_addr     <= '0;
            sram_wdata    <= '0;
            sram_wdata_oe <= 1'b0;
            sram_ce_n     <= 1'b1;
            sram_oe_n     <= 1'b1;
            sram_we_n     <= 1'b1;
            sram_be_n     <= '1;
        end else if (start) begin
            active_q      <= 1'b1;
            we_q          <= cmd.we;
            cnt_q         <= '0;
            sram_addr     <= addr;
            sram_wdata    <= cmd.wdata;
            sram_wdata_oe <= cmd.we;
            sram_ce_n     <= 1'b0;
            sram_oe_n     <= cmd.we;
            sram_we_n     <= 1'b1;
            sram_be_n     <= cmd.we ? ~cmd.be : '0;
        end else if (active_q) begin
            if (cnt_q == CNT_LAST) begin
                active_q      <= 1'b0;
                sram_wdata_oe <= 1'b0;
                sram_ce_n     <= 1'b1;
                sram_oe_n     <= 1'b1;
                sram_we_n     <= 1'b1;
                sram_be_n     <= '1;
                if (!we_q) begin
                    rdata <= sram_rdata;
                end
            end else begin
                cnt_q     <= cnt_inc;
                // First and last cycle keep we_n high for address/data setup and hold.
                sram_we_n <= !(we_q && (cnt_inc <= WE_LOW_END));
            end
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Shares the base-SRAM port between Icache refill and the MEM stage with alternating priority.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int unsigned SRAM_AW       = 20,
    parameter int unsigned ACCESS_CYCLES = ACCESS_CYCLES_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               if_req,
    input  logic [31:0]        if_addr,
    input  logic               if_flush,
    output logic [31:0]        if_rdata,
    output logic               if_ack,
    output logic               inst_stop,
    input  logic               dm_req,
    input  logic               dm_we,
    input  logic [3:0]         dm_be,
    input  logic [31:0]        dm_addr,
    input  logic [31:0]        dm_wdata,
    output logic [31:0]        dm_rdata,
    output logic               dm_ack,
    output logic               dm_stall,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [31:0]        sram_wdata,
    output logic               sram_wdata_oe,
    input  logic [31:0]        sram_rdata,
    output logic               sram_ce_n,
    output logic               sram_oe_n,
    output logic               sram_we_n,
    output logic [3:0]         sram_be_n
);

    arb_state_e         state_q, state_d;
    owner_e             owner_q, owner_d;
    owner_e             last_grant_q, last_grant_d;
    logic               drop_q, drop_d;
    logic               we_q, we_d;
    logic               if_ack_d, dm_ack_d;
    logic [DATA_W-1:0]  dm_hold_q, dm_hold_d;

    logic               if_ok;
    logic               grant_dm;
    logic               grant_if;
    logic               start;
    logic               phy_last_c;
    logic [DATA_W-1:0]  phy_rdata;
    sram_cmd_t          cmd;
    logic [SRAM_AW-1:0] addr_sel;
    logic               unused_addr_bits;

    // A flushed fetch is not a valid request; contention falls back to last_grant.
    assign if_ok    = if_req & ~if_flush;
    assign grant_dm = dm_req & (~if_ok | (last_grant_q == OWN_IF));
    assign grant_if = if_ok & ~grant_dm;
    assign start    = (state_q == ARB_IDLE) & (grant_dm | grant_if);

    assign addr_sel  = grant_dm ? dm_addr[SRAM_AW+1:2] : if_addr[SRAM_AW+1:2];
    assign cmd.we    = grant_dm & dm_we;
    assign cmd.be    = grant_dm ? dm_be : 4'hF;
    assign cmd.wdata = dm_wdata;

    assign unused_addr_bits = ^{if_addr[31:SRAM_AW+2], if_addr[1:0],
                                dm_addr[31:SRAM_AW+2], dm_addr[1:0]};

    assign inst_stop = (state_q == ARB_IDLE) ? grant_dm : (owner_q == OWN_DM);
    assign dm_stall  = dm_req & ~dm_ack;

    // Fetch data comes straight from the capture register; load data is held across stores.
    assign if_rdata = phy_rdata;
    assign dm_rdata = (dm_ack && !we_q) ? phy_rdata : dm_hold_q;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        drop_d       = drop_q;
        we_d         = we_q;
        dm_hold_d    = dm_hold_q;
        if_ack_d     = 1'b0;
        dm_ack_d     = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (start) begin
                    state_d      = ARB_ACCESS;
                    owner_d      = grant_dm ? OWN_DM : OWN_IF;
                    last_grant_d = grant_dm ? OWN_DM : OWN_IF;
                    we_d         = cmd.we;
                end
            end
            ARB_ACCESS: begin
                if ((owner_q == OWN_IF) && if_flush) begin
                    drop_d = 1'b1;
                end
                if (phy_last_c) begin
                    state_d  = ARB_DONE;
                    if_ack_d = (owner_q == OWN_IF) & ~drop_d;
                    dm_ack_d = (owner_q == OWN_DM);
                end
            end
            ARB_DONE: begin
                state_d = ARB_IDLE;
                drop_d  = 1'b0;
                if ((owner_q == OWN_DM) && !we_q) begin
                    dm_hold_d = phy_rdata;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ARB_IDLE;
            owner_q      <= OWN_IF;
            last_grant_q <= OWN_IF;
            drop_q       <= 1'b0;
            we_q         <= 1'b0;
            dm_hold_q    <= '0;
            if_ack       <= 1'b0;
            dm_ack       <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            drop_q       <= drop_d;
            we_q         <= we_d;
            dm_hold_q    <= dm_hold_d;
            if_ack       <= if_ack_d;
            dm_ack       <= dm_ack_d;
        end
    end

    sram_phy_seq #(
        .SRAM_AW       (SRAM_AW),
        .ACCESS_CYCLES (ACCESS_CYCLES)
    ) u_phy (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .cmd           (cmd),
        .addr          (addr_sel),
        .sram_rdata    (sram_rdata),
        .last_c        (phy_last_c),
        .rdata         (phy_rdata),
        .sram_addr     (sram_addr),
        .sram_wdata    (sram_wdata),
        .sram_wdata_oe (sram_wdata_oe),
        .sram_ce_n     (sram_ce_n),
        .sram_oe_n     (sram_oe_n),
        .sram_we_n     (sram_we_n),
        .sram_be_n     (sram_be_n)
    );

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed, table-driven bench for sram_arbiter (default and 5-cycle access builds).
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_flush, dm_req, dm_we, d5_dm_req;
    logic [31:0] if_addr, dm_addr, dm_wdata, sram_rdata;
    logic [3:0]  dm_be;

    logic [31:0] if_rdata, dm_rdata, sram_wdata;
    logic        if_ack, inst_stop, dm_ack, dm_stall, sram_wdata_oe;
    logic        sram_ce_n, sram_oe_n, sram_we_n;
    logic [3:0]  sram_be_n;
    logic [19:0] sram_addr;

    logic [31:0] d5_if_rdata, d5_dm_rdata, d5_sram_wdata;
    logic        d5_if_ack, d5_inst_stop, d5_dm_ack, d5_dm_stall, d5_wdata_oe;
    logic        d5_ce_n, d5_oe_n, d5_we_n;
    logic [3:0]  d5_be_n;
    logic [19:0] d5_sram_addr;

    logic [7:0]  strb;
    assign strb = {sram_ce_n, sram_oe_n, sram_we_n, sram_be_n, sram_wdata_oe};

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sram_arbiter dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_rdata(if_rdata), .if_ack(if_ack), .inst_stop(inst_stop),
        .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ack(dm_ack), .dm_stall(dm_stall),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_wdata_oe(sram_wdata_oe),
        .sram_rdata(sram_rdata), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n), .sram_be_n(sram_be_n)
    );

    sram_arbiter #(.SRAM_AW(20), .ACCESS_CYCLES(5)) dut5 (
        .clk(clk), .rst(rst),
        .if_req(1'b0), .if_addr(if_addr), .if_flush(1'b0),
        .if_rdata(d5_if_rdata), .if_ack(d5_if_ack), .inst_stop(d5_inst_stop),
        .dm_req(d5_dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_rdata(d5_dm_rdata), .dm_ack(d5_dm_ack), .dm_stall(d5_dm_stall),
        .sram_addr(d5_sram_addr), .sram_wdata(d5_sram_wdata), .sram_wdata_oe(d5_wdata_oe),
        .sram_rdata(sram_rdata), .sram_ce_n(d5_ce_n), .sram_oe_n(d5_oe_n),
        .sram_we_n(d5_we_n), .sram_be_n(d5_be_n)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic       if_req;
        logic       dm_req;
        logic       dm_we;
        logic [3:0] dm_be;
        logic [7:0] strb;   // {ce_n, oe_n, we_n, be_n[3:0], wdata_oe}
        logic [1:0] acks;   // {if_ack, dm_ack}
        logic       stop;
        logic       stall;
    } vec_t;

    vec_t tbl [12];

    initial begin
        // IF read of 0x8000_0010, then DM store to 0x8000_0104 be=0011.
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 4'h0, 8'hFE, 2'b00, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 4'h0, 8'h20, 2'b00, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 4'h0, 8'h20, 2'b00, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 4'h0, 8'h20, 2'b00, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 4'h0, 8'hFE, 2'b10, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 4'h0, 8'hFE, 2'b00, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 1'b1, 4'h3, 8'hFE, 2'b00, 1'b1, 1'b1};
        tbl[7]  = '{1'b0, 1'b1, 1'b1, 4'h3, 8'h79, 2'b00, 1'b1, 1'b1};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 4'h3, 8'h59, 2'b00, 1'b1, 1'b1};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 4'h3, 8'h79, 2'b00, 1'b1, 1'b1};
        tbl[10] = '{1'b0, 1'b1, 1'b1, 4'h3, 8'hFE, 2'b01, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 4'h0, 8'hFE, 2'b00, 1'b0, 1'b0};

        rst = 1'b0; if_req = 1'b0; if_flush = 1'b0; dm_req = 1'b0; d5_dm_req = 1'b0;
        dm_we = 1'b0; dm_be = 4'h0;
        if_addr = 32'h8000_0010; dm_addr = 32'h8000_0104;
        dm_wdata = 32'hDEAD_BEEF; sram_rdata = 32'h2402_0005;

        // Reset state
        @(negedge clk); #1;
        chk("rst_strb", 32'(strb), 32'hFE);
        chk("rst_acks", 32'({if_ack, dm_ack}), 32'h0);
        chk("rst_stop", 32'({inst_stop, dm_stall}), 32'h0);
        chk("rst_if_rdata", if_rdata, 32'h0);
        chk("rst_dm_rdata", dm_rdata, 32'h0);
        chk("rst_sram_addr", 32'(sram_addr), 32'h0);
        chk("rst_sram_wdata", sram_wdata, 32'h0);
        @(negedge clk); rst = 1'b1;

        // Table-driven IF read and DM store
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if_req = tbl[i].if_req; dm_req = tbl[i].dm_req;
            dm_we = tbl[i].dm_we; dm_be = tbl[i].dm_be;
            #1;
            chk($sformatf("tbl%0d_strb", i), 32'(strb), 32'(tbl[i].strb));
            chk($sformatf("tbl%0d_acks", i), 32'({if_ack, dm_ack}), 32'(tbl[i].acks));
            chk($sformatf("tbl%0d_stop", i), 32'(inst_stop), 32'(tbl[i].stop));
            chk($sformatf("tbl%0d_stall", i), 32'(dm_stall), 32'(tbl[i].stall));
            if (i == 2) chk("if_sram_addr", 32'(sram_addr), 32'h0_0004);
            if (i == 4) chk("if_rdata", if_rdata, 32'h2402_0005);
            if (i == 8) chk("st_sram_addr", 32'(sram_addr), 32'h0_0041);
            if (i == 8) chk("st_sram_wdata", sram_wdata, 32'hDEAD_BEEF);
            if (i == 10) chk("st_dm_rdata_hold", dm_rdata, 32'h0);
            if (i == 11) chk("idle_addr_hold", 32'(sram_addr), 32'h0_0041);
        end

        // Continuous contention from reset: DM, IF, DM, IF
        @(negedge clk); rst = 1'b0;
        @(negedge clk); rst = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if_req = 1'b1; dm_req = 1'b1; dm_we = 1'b0; dm_be = 4'hF;
            #1;
            chk($sformatf("cont%0d_acks", c), 32'({if_ack, dm_ack}),
                32'((c % 5 == 4) ? (((c / 5) % 2 == 1) ? 2'b10 : 2'b01) : 2'b00));
            chk($sformatf("cont%0d_stop", c), 32'(inst_stop), 32'((c / 5) % 2 == 0));
        end
        @(negedge clk);
        if_req = 1'b0; dm_req = 1'b0;
        #1;
        chk("cont_end_strb", 32'(strb), 32'hFE);

        // Flush: blocked in IDLE, then dropped mid-access, then a clean fetch
        @(negedge clk); if_req = 1'b1; if_flush = 1'b1; #1;
        chk("flush_idle_stop", 32'(inst_stop), 32'h0);
        @(negedge clk); if_flush = 1'b0; #1;
        chk("flush_idle_blocked", 32'(strb), 32'hFE);
        @(negedge clk); #1;
        chk("flush_acc1", 32'(strb), 32'h20);
        @(negedge clk); if_flush = 1'b1; if_req = 1'b0; #1;
        chk("flush_acc2", 32'(strb), 32'h20);
        @(negedge clk); if_flush = 1'b0; #1;
        chk("flush_acc3", 32'(strb), 32'h20);
        @(negedge clk); #1;
        chk("flush_done_strb", 32'(strb), 32'hFE);
        chk("flush_no_ack", 32'(if_ack), 32'h0);
        @(negedge clk); sram_rdata = 32'h1122_3344; if_req = 1'b1; #1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk); #1;
            chk($sformatf("refetch%0d_ack", c), 32'(if_ack), 32'(c == 4));
        end
        chk("refetch_rdata", if_rdata, 32'h1122_3344);
        @(negedge clk); if_req = 1'b0;

        // Reset during ACCESS cycle 2 of a store
        @(negedge clk); dm_req = 1'b1; dm_we = 1'b1; dm_be = 4'h3; #1;
        @(negedge clk); #1;
        @(negedge clk); #1;
        chk("rmid_we_low", 32'(strb), 32'h59);
        rst = 1'b0; #1;
        chk("rmid_abort", 32'(strb), 32'hFE);
        @(negedge clk); dm_req = 1'b0; dm_we = 1'b0; #1;
        chk("rmid_next", 32'(strb), 32'hFE);
        rst = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk); #1;
            chk($sformatf("rmid_noack%0d", c), 32'({dm_ack, dm_stall}), 32'h0);
        end

        // ACCESS_CYCLES = 5 load
        sram_rdata = 32'hCAFE_0123;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            d5_dm_req = (c < 7); dm_we = 1'b0; dm_be = 4'hF;
            #1;
            chk($sformatf("ac5_%0d_oe_n", c), 32'(d5_oe_n), 32'(!(c >= 1 && c <= 5)));
            chk($sformatf("ac5_%0d_we_n", c), 32'(d5_we_n), 32'h1);
            chk($sformatf("ac5_%0d_ack", c), 32'(d5_dm_ack), 32'(c == 6));
            if (c == 6) chk("ac5_rdata", d5_dm_rdata, 32'hCAFE_0123);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
